// File: rtl/key_pkg.sv
// Shared definitions for the chunked key/message path (serializer and receiver).
package key_pkg;

    localparam int unsigned DEFAULT_KEY_SIZE = 4;
    localparam int unsigned DEFAULT_MSG_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/disassemble_key_if.sv
// Word-in / chunk-out handshake bundle for disassemble_key.
interface disassemble_key_if
    import key_pkg::*;
#(
    parameter int unsigned KEY_SIZE = DEFAULT_KEY_SIZE,
    parameter int unsigned MSG_SIZE = DEFAULT_MSG_SIZE
);
    localparam int unsigned NUM_CHUNKS = MSG_SIZE / KEY_SIZE;
    localparam int unsigned IDX_W      = $clog2(NUM_CHUNKS);

    logic [MSG_SIZE-1:0] iMsg;
    logic                iMsgValid;
    logic                oMsgReady;
    logic [KEY_SIZE-1:0] oKey;
    logic                oKeyValid;
    logic                iKeyReady;
    logic                oKeyLast;
    logic [IDX_W-1:0]    oIdx;
    logic                oDisassembled;

    modport master (
        output iMsg, iMsgValid, iKeyReady,
        input  oMsgReady, oKey, oKeyValid, oKeyLast, oIdx, oDisassembled
    );

    modport slave (
        input  iMsg, iMsgValid, iKeyReady,
        output oMsgReady, oKey, oKeyValid, oKeyLast, oIdx, oDisassembled
    );

endinterface

// File: rtl/disassemble_key.sv
// Serializes one MSG_SIZE-bit word into KEY_SIZE-bit chunks, MSB chunk first,
// with valid/ready on both sides and a global enable.
module disassemble_key
    import key_pkg::*;
#(
    parameter int unsigned KEY_SIZE = DEFAULT_KEY_SIZE,
    parameter int unsigned MSG_SIZE = DEFAULT_MSG_SIZE
) (
    input logic             iClk,
    input logic             iRst,
    input logic             iEn,
    disassemble_key_if.slave bus
);
    localparam int unsigned NUM_CHUNKS = MSG_SIZE / KEY_SIZE;
    localparam int unsigned IDX_W      = $clog2(NUM_CHUNKS);

    if ((MSG_SIZE % KEY_SIZE) != 0 || MSG_SIZE < 2 * KEY_SIZE) begin : g_bad_params
        $error("disassemble_key: MSG_SIZE must be a multiple of KEY_SIZE and >= 2*KEY_SIZE");
    end

    state_t              state, state_nxt;
    logic [MSG_SIZE-1:0] shreg, shreg_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                last;

    assign last = (idx == IDX_W'(NUM_CHUNKS - 1));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            idx   <= idx_nxt;
        end
    end

    // idx stays at the last index on the final transfer so it never wraps.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        unique case (state)
            IDLE: begin
                if (iEn && bus.iMsgValid) begin
                    shreg_nxt = bus.iMsg;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (iEn && bus.iKeyReady) begin
                    shreg_nxt = {shreg[MSG_SIZE-KEY_SIZE-1:0], {KEY_SIZE{1'b0}}};
                    if (last) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            DONE: begin
                shreg_nxt = '0;
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.oMsgReady     = (state == IDLE) && !iRst;
    assign bus.oKeyValid     = (state == SEND);
    assign bus.oKey          = (state == SEND) ? shreg[MSG_SIZE-1 -: KEY_SIZE] : '0;
    assign bus.oKeyLast      = (state == SEND) && last;
    assign bus.oIdx          = idx;
    assign bus.oDisassembled = (state == DONE);

endmodule

// File: tb/tb_disassemble_key.sv
// Checks disassemble_key against a word/chunk-number model plus directed literal cases.
module tb_disassemble_key;

    logic clk;
    logic rst;
    logic en;

    int n_tests = 0;
    int n_fail  = 0;

    disassemble_key_if #(.KEY_SIZE(4), .MSG_SIZE(8))  b8 ();
    disassemble_key_if #(.KEY_SIZE(4), .MSG_SIZE(16)) b16 ();

    disassemble_key #(.KEY_SIZE(4), .MSG_SIZE(8)) dut8 (
        .iClk(clk), .iRst(rst), .iEn(en), .bus(b8)
    );

    disassemble_key #(.KEY_SIZE(4), .MSG_SIZE(16)) dut16 (
        .iClk(clk), .iRst(rst), .iEn(en), .bus(b16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the 8-bit instance: busy with word m_word, presenting chunk m_n.
    bit       started = 1'b0;
    bit       m_busy  = 1'b0;
    bit       m_done  = 1'b0;
    bit [7:0] m_word  = '0;
    int       m_n     = 0;

    function automatic int chunk8(input bit [7:0] w, input int n);
        return int'((w >> (8 - 4 * (n + 1))) & 8'h0F);
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_n    = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_busy) begin
            if (en && b8.iMsgValid) begin
                m_busy = 1'b1;
                m_word = b8.iMsg;
                m_n    = 0;
            end
        end else if (en && b8.iKeyReady) begin
            if (m_n == 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_n++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ready", int'(b8.oMsgReady), int'(!m_busy && !m_done && !rst));
            check("kvalid", int'(b8.oKeyValid), int'(m_busy));
            check("key", int'(b8.oKey), m_busy ? chunk8(m_word, m_n) : 0);
            check("last", int'(b8.oKeyLast), int'(m_busy && m_n == 1));
            check("done", int'(b8.oDisassembled), int'(m_done));
            if (!m_done) check("idx", int'(b8.oIdx), m_busy ? m_n : 0);
        end
    end

    // Transfer monitors feeding the stream-level directed checks.
    int q8[$];
    int q16[$];
    int d8  = 0;
    int d16 = 0;

    always @(negedge clk) begin
        if (b8.oKeyValid && b8.iKeyReady && en) q8.push_back(int'(b8.oKey));
        if (b8.oDisassembled) d8++;
        if (b16.oKeyValid && b16.iKeyReady && en)
            q16.push_back(int'({b16.oKeyLast, b16.oKey}));
        if (b16.oDisassembled) d16++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send8(input logic [7:0] w);
        b8.iMsg      = w;
        b8.iMsgValid = 1'b1;
        tick();
        b8.iMsgValid = 1'b0;
    endtask

    task automatic chk_out8(input string name, input int key, input int idx, input int last);
        check({name, "_key"}, int'(b8.oKey), key);
        check({name, "_idx"}, int'(b8.oIdx), idx);
        check({name, "_last"}, int'(b8.oKeyLast), last);
        check({name, "_valid"}, int'(b8.oKeyValid), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        b8.iMsg = '0;   b8.iMsgValid = 1'b0;  b8.iKeyReady = 1'b1;
        b16.iMsg = '0;  b16.iMsgValid = 1'b0; b16.iKeyReady = 1'b1;
        tick();
        tick();

        check("rst_ready", int'(b8.oMsgReady), 0);
        check("rst_kvalid", int'(b8.oKeyValid), 0);
        check("rst_key", int'(b8.oKey), 0);
        check("rst_idx", int'(b8.oIdx), 0);
        check("rst_done", int'(b8.oDisassembled), 0);
        rst = 1'b0;
        #1;
        check("idle_ready", int'(b8.oMsgReady), 1);

        // A5 with no backpressure
        tick();
        send8(8'hA5);
        chk_out8("a5_c1", 'hA, 0, 0);
        tick();
        chk_out8("a5_c2", 'h5, 1, 1);
        tick();
        check("a5_c3_done", int'(b8.oDisassembled), 1);
        check("a5_c3_ready", int'(b8.oMsgReady), 0);
        tick();
        check("a5_c4_done", int'(b8.oDisassembled), 0);
        check("a5_c4_ready", int'(b8.oMsgReady), 1);

        // 16-bit word 1234 on the wide instance
        b16.iMsg      = 16'h1234;
        b16.iMsgValid = 1'b1;
        tick();
        b16.iMsgValid = 1'b0;
        repeat (6) tick();
        check("w16_count", q16.size(), 4);
        if (q16.size() == 4) begin
            check("w16_c0", q16[0], 'h01);
            check("w16_c1", q16[1], 'h02);
            check("w16_c2", q16[2], 'h03);
            check("w16_c3", q16[3], 'h14);
        end
        check("w16_done_pulses", d16, 1);

        // C3 with backpressure on the first chunk
        b8.iKeyReady = 1'b0;
        send8(8'hC3);
        repeat (3) begin
            chk_out8("bp_hold", 'hC, 0, 0);
            tick();
        end
        chk_out8("bp_hold", 'hC, 0, 0);
        b8.iKeyReady = 1'b1;
        tick();
        chk_out8("bp_release", 'h3, 1, 1);
        tick();
        tick();

        // Enable dropped mid-SEND, then in IDLE
        send8(8'h96);
        chk_out8("en_c1", 'h9, 0, 0);
        en = 1'b0;
        tick();
        chk_out8("en_frz1", 'h9, 0, 0);
        tick();
        chk_out8("en_frz2", 'h9, 0, 0);
        en = 1'b1;
        tick();
        chk_out8("en_resume", 'h6, 1, 1);
        tick();
        tick();
        en = 1'b0;
        b8.iMsg      = 8'hFF;
        b8.iMsgValid = 1'b1;
        tick();
        tick();
        check("en_idle_noaccept", int'(b8.oKeyValid), 0);
        check("en_idle_ready", int'(b8.oMsgReady), 1);
        b8.iMsgValid = 1'b0;
        en = 1'b1;
        tick();

        // Reset after the first chunk of 5A
        send8(8'h5A);
        chk_out8("rm_c1", 'h5, 0, 0);
        rst = 1'b1;
        tick();
        check("rm_kvalid", int'(b8.oKeyValid), 0);
        check("rm_key", int'(b8.oKey), 0);
        check("rm_idx", int'(b8.oIdx), 0);
        check("rm_last", int'(b8.oKeyLast), 0);
        check("rm_done", int'(b8.oDisassembled), 0);
        check("rm_ready_in_rst", int'(b8.oMsgReady), 0);
        rst = 1'b0;
        #1;
        check("rm_ready_after", int'(b8.oMsgReady), 1);
        tick();
        send8(8'h3C);
        chk_out8("rm_n1", 'h3, 0, 0);
        tick();
        chk_out8("rm_n2", 'hC, 1, 1);
        tick();
        tick();

        // Back-to-back words with valid held high
        q8.delete();
        d8 = 0;
        b8.iMsg      = 8'h12;
        b8.iMsgValid = 1'b1;
        tick();
        b8.iMsg = 8'h34;
        repeat (4) tick();
        b8.iMsgValid = 1'b0;
        repeat (4) tick();
        check("b2b_count", q8.size(), 4);
        if (q8.size() == 4) begin
            check("b2b_c0", q8[0], 'h1);
            check("b2b_c1", q8[1], 'h2);
            check("b2b_c2", q8[2], 'h3);
            check("b2b_c3", q8[3], 'h4);
        end
        check("b2b_done_pulses", d8, 2);

        // Randomized traffic against the model
        repeat (500) begin
            rst          = ($urandom_range(0, 49) == 0);
            en           = ($urandom_range(0, 7) != 0);
            b8.iMsgValid = 1'($urandom_range(0, 1));
            b8.iKeyReady = ($urandom_range(0, 2) != 0);
            b8.iMsg      = 8'($urandom);
            tick();
        end
        rst          = 1'b0;
        en           = 1'b1;
        b8.iMsgValid = 1'b0;
        b8.iKeyReady = 1'b1;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
